note_envelope_ctrl: RTL and testbench
=====================================

// Module: note_envelope_ctrl
// PURPOSE
//  Consumes the 4-bit key index from the keyboard key mapper (0 = no key, 1..12 = C4..B4).
//  Detects press, release and key-change events on that index.
//  Outputs a DDS phase increment plus a linear attack/sustain/release amplitude envelope.
//  Sits between the key mapper and the oscillator/sample-playback voice; envelope steps on the audio sample tick.
// PARAMETERS
//  PHASE_W       24      phase-increment width; DDS accumulator is PHASE_W bits at 48 kHz
//  ENV_W         16      envelope amplitude width; full scale = 2^ENV_W-1
//  ATTACK_STEP   64      amplitude added per sample_tick in ATTACK
//  RELEASE_STEP  16      amplitude subtracted per sample_tick in RELEASE
// PORTS
//  Clk          in   1        system clock
//  Reset_n      in   1        asynchronous, active-low reset
//  key_idx      in   4        key index from key mapper; 13..15 treated as 0
//  sample_tick  in   1        1-cycle strobe at audio sample rate (48 kHz)
//  octave       in   2        octave shift 0..3 (present only with NOTE_OCTAVE_SHIFT_EN)
//  phase_inc    out  PHASE_W  DDS phase increment of current note
//  amp          out  ENV_W    envelope amplitude
//  gate         out  1        1 while a key is held (ATTACK or SUSTAIN)
//  voice_active out  1        1 whenever state != IDLE
//  note_idx     out  4        index of note currently sounding; 0 when IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; internal key registers 0.
//  Input stage: key_idx registered into k_q; k_q delayed into k_d. Events are decoded from k_q vs k_d:
//   - press:  k_d==0 && k_q!=0
//   - rel:    k_d!=0 && k_q==0
//   - change: k_d!=0 && k_q!=0 && k_q!=k_d
//   gate rises 2 clocks after key_idx first presents a nonzero value.
//  Pitch ROM: base_inc(k) = round(440*2^((k-10)/12) * 2^24 / 48000).
//   Examples: k=1 -> 91445; k=10 -> 153791.
//   phase_inc and note_idx load on press or change, in the same cycle the state updates.
//   Both hold through RELEASE. phase_inc also holds its last value in IDLE; note_idx clears to 0 in IDLE.
//  FSM: IDLE, ATTACK, SUSTAIN, RELEASE.
//   - IDLE    -> ATTACK on press.
//   - ATTACK  on tick: amp = min(amp+ATTACK_STEP, max); at max -> SUSTAIN. On rel -> RELEASE.
//   - SUSTAIN holds amp=max; on rel -> RELEASE.
//   - RELEASE on tick: amp = max(amp-RELEASE_STEP, 0); at 0 -> IDLE.
//             On press -> ATTACK, amp continues from its current value (no click).
//  change in ATTACK or SUSTAIN: legato. Pitch and note_idx update; state and amp are unchanged.
//  Arithmetic: ENV_W+1-bit intermediate, saturating; amp never wraps.
//  Simultaneous event and sample_tick: the event wins; no amp step that cycle; stepping resumes on the next tick.
//  A press cycle that also carries a tick: no step that cycle; the first step comes on the next tick.
//  No ticks: state transitions still occur; amp frozen.
//  Reset_n asserted mid-note: immediate return to IDLE with amp=0 (async); no release tail.
// CONFIGURATION
//  NOTE_OCTAVE_SHIFT_EN defined:
//   - octave port exists; phase_inc = base_inc(k) << octave.
//   - octave is sampled only on press or change; changing octave while a key is held has no effect.
//  NOTE_OCTAVE_SHIFT_EN undefined: no octave port; phase_inc = base_inc(k).
// TESTING
//  1. Reset_n=0, then release -> all outputs 0; state IDLE; amp=0 with ticks running.
//  2. key_idx=10 held, tick every 4 clks -> gate=1 2 clks after key, phase_inc=153791, note_idx=10.
//     amp +64 per tick; SUSTAIN with amp=65535 after 1024 ticks.
//  3. From SUSTAIN, key_idx->0 -> gate=0, RELEASE; amp -16 per tick; IDLE and voice_active=0 after 4096 ticks; note_idx=0.
//  4. Legato: hold 1 in ATTACK (amp=640), switch to 10 -> phase_inc 91445->153791; amp keeps stepping from 640; no re-attack.
//  5. Retrigger: key 1 released with amp=1000, tick coincident with new press of 3 -> ATTACK.
//     amp stays 1000 that cycle, then 1064 on the next tick; note_idx=3.
//  6. With NOTE_OCTAVE_SHIFT_EN, octave=2, press 10 -> phase_inc=615164.
//     Change octave to 0 while held -> phase_inc unchanged.

Source files
------------

// File: rtl/note_envelope_ctrl_if.sv
// Key-mapper / voice connection bundle for note_envelope_ctrl.
// The octave signal exists only when NOTE_OCTAVE_SHIFT_EN is defined.
interface note_envelope_ctrl_if #(
    parameter int PHASE_W = 24,
    parameter int ENV_W   = 16
);
    logic [3:0]         key_idx;
    logic               sample_tick;
`ifdef NOTE_OCTAVE_SHIFT_EN
    logic [1:0]         octave;
`endif
    logic [PHASE_W-1:0] phase_inc;
    logic [ENV_W-1:0]   amp;
    logic               gate;
    logic               voice_active;
    logic [3:0]         note_idx;

`ifdef NOTE_OCTAVE_SHIFT_EN
    modport master (output key_idx, sample_tick, octave,
                    input  phase_inc, amp, gate, voice_active, note_idx);
    modport slave  (input  key_idx, sample_tick, octave,
                    output phase_inc, amp, gate, voice_active, note_idx);
`else
    modport master (output key_idx, sample_tick,
                    input  phase_inc, amp, gate, voice_active, note_idx);
    modport slave  (input  key_idx, sample_tick,
                    output phase_inc, amp, gate, voice_active, note_idx);
`endif
endinterface

// File: rtl/note_envelope_ctrl.sv
// Key event decode, pitch ROM and linear attack/sustain/release envelope.
// Optional NOTE_OCTAVE_SHIFT_EN: phase_inc shifted left by octave sampled on press/change.
//
// state   | meaning
// IDLE    | silent, no note
// ATTACK  | key held, amp ramping up per sample_tick
// SUSTAIN | key held, amp at full scale
// RELEASE | key released, amp ramping down to 0
module note_envelope_ctrl #(
    parameter int PHASE_W      = 24,
    parameter int ENV_W        = 16,
    parameter int ATTACK_STEP  = 64,
    parameter int RELEASE_STEP = 16
) (
    input logic               clk,
    input logic               reset_n,
    note_envelope_ctrl_if.slave ne
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ATTACK  = 2'd1;
    localparam logic [1:0] S_SUSTAIN = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [ENV_W-1:0] AMP_MAX = '1;

    logic [1:0]         state;
    logic [3:0]         k_q, k_d, key_in;
    logic [ENV_W-1:0]   amp_q;
    logic [PHASE_W-1:0] inc_q, inc_new;
    logic [3:0]         note_q;
    logic               press, rel, change;
    logic [ENV_W:0]     amp_up, amp_dn;
    logic [ENV_W-1:0]   amp_up_sat, amp_dn_sat;

    function automatic logic [PHASE_W-1:0] base_inc(input logic [3:0] k);
        logic [PHASE_W-1:0] v;
        case (k)
            4'd1:    v = PHASE_W'(91445);
            4'd2:    v = PHASE_W'(96882);
            4'd3:    v = PHASE_W'(102643);
            4'd4:    v = PHASE_W'(108747);
            4'd5:    v = PHASE_W'(115213);
            4'd6:    v = PHASE_W'(122064);
            4'd7:    v = PHASE_W'(129322);
            4'd8:    v = PHASE_W'(137012);
            4'd9:    v = PHASE_W'(145160);
            4'd10:   v = PHASE_W'(153791);
            4'd11:   v = PHASE_W'(162936);
            4'd12:   v = PHASE_W'(172625);
            default: v = '0;
        endcase
        return v;
    endfunction

    assign key_in = (ne.key_idx > 4'd12) ? 4'd0 : ne.key_idx;

    assign press  = (k_d == 4'd0) && (k_q != 4'd0);
    assign rel    = (k_d != 4'd0) && (k_q == 4'd0);
    assign change = (k_d != 4'd0) && (k_q != 4'd0) && (k_q != k_d);

`ifdef NOTE_OCTAVE_SHIFT_EN
    assign inc_new = base_inc(k_q) << ne.octave;
`else
    assign inc_new = base_inc(k_q);
`endif

    // One extra bit catches overflow on attack and borrow on release.
    assign amp_up     = {1'b0, amp_q} + (ENV_W+1)'(ATTACK_STEP);
    assign amp_dn     = {1'b0, amp_q} - (ENV_W+1)'(RELEASE_STEP);
    assign amp_up_sat = amp_up[ENV_W] ? AMP_MAX : amp_up[ENV_W-1:0];
    assign amp_dn_sat = amp_dn[ENV_W] ? '0 : amp_dn[ENV_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q    <= '0;
            k_d    <= '0;
            state  <= S_IDLE;
            amp_q  <= '0;
            inc_q  <= '0;
            note_q <= '0;
        end else begin
            k_q <= key_in;
            k_d <= k_q;
            case (state)
                S_IDLE: begin
                    if (press) begin
                        state  <= S_ATTACK;
                        inc_q  <= inc_new;
                        note_q <= k_q;
                    end
                end
                S_ATTACK, S_SUSTAIN: begin
                    if (rel) begin
                        state <= S_RELEASE;
                    end else if (change) begin
                        inc_q  <= inc_new;
                        note_q <= k_q;
                    end else if (state == S_ATTACK && ne.sample_tick) begin
                        amp_q <= amp_up_sat;
                        if (amp_up_sat == AMP_MAX) state <= S_SUSTAIN;
                    end
                end
                S_RELEASE: begin
                    // Retrigger keeps the current amp so the attack ramps on without a click.
                    if (press) begin
                        state  <= S_ATTACK;
                        inc_q  <= inc_new;
                        note_q <= k_q;
                    end else if (ne.sample_tick) begin
                        amp_q <= amp_dn_sat;
                        if (amp_dn_sat == '0) begin
                            state  <= S_IDLE;
                            note_q <= '0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ne.phase_inc    = inc_q;
    assign ne.amp          = amp_q;
    assign ne.gate         = (state == S_ATTACK) || (state == S_SUSTAIN);
    assign ne.voice_active = (state != S_IDLE);
    assign ne.note_idx     = note_q;
endmodule

// File: tb/tb_note_envelope_ctrl.sv
// Self-checking bench for note_envelope_ctrl: directed scenarios plus random key/tick traffic
// against a behavioural envelope model.
module tb_note_envelope_ctrl;
    localparam int PHASE_W = 24;
    localparam int ENV_W   = 16;
    localparam int FULL    = 65535;
    localparam int M_IDLE = 0, M_ATK = 1, M_SUS = 2, M_REL = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    int          m_kq, m_kd, m_mode, m_amp, m_note;
    int unsigned m_inc;
    int          cur_oct = 0;

    always #5 clk = ~clk;

    note_envelope_ctrl_if #(.PHASE_W(PHASE_W), .ENV_W(ENV_W)) ne ();

    note_envelope_ctrl #(
        .PHASE_W(PHASE_W), .ENV_W(ENV_W), .ATTACK_STEP(64), .RELEASE_STEP(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ne(ne)
    );

    function automatic int unsigned ref_inc(input int k, input int oct);
        real f;
        f = 440.0 * (2.0 ** (real'(k - 10) / 12.0));
        return int'($rtoi(f * 16777216.0 / 48000.0 + 0.5)) << oct;
    endfunction

    task automatic model_reset();
        m_kq = 0; m_kd = 0; m_mode = M_IDLE; m_amp = 0; m_note = 0; m_inc = 0;
    endtask

    task automatic model_load(input int oct);
        m_inc  = ref_inc(m_kq, oct);
        m_note = m_kq;
    endtask

    // One clock edge of the envelope as described by the behavioural rules.
    task automatic model_clock(input int key, input bit tick, input int oct);
        bit pr, rl, ch;
        pr = (m_kd == 0) && (m_kq != 0);
        rl = (m_kd != 0) && (m_kq == 0);
        ch = (m_kd != 0) && (m_kq != 0) && (m_kq != m_kd);
        if (m_mode == M_IDLE) begin
            if (pr) begin m_mode = M_ATK; model_load(oct); end
        end else if (m_mode == M_REL) begin
            if (pr) begin
                m_mode = M_ATK; model_load(oct);
            end else if (tick) begin
                m_amp = (m_amp > 16) ? m_amp - 16 : 0;
                if (m_amp == 0) begin m_mode = M_IDLE; m_note = 0; end
            end
        end else begin
            if (rl) m_mode = M_REL;
            else if (ch) model_load(oct);
            else if (tick && m_mode == M_ATK) begin
                m_amp = (m_amp + 64 > FULL) ? FULL : m_amp + 64;
                if (m_amp == FULL) m_mode = M_SUS;
            end
        end
        m_kd = m_kq;
        m_kq = (key > 12) ? 0 : key;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("phase_inc", 32'(ne.phase_inc), m_inc);
        check("amp", 32'(ne.amp), m_amp);
        check("gate", 32'(ne.gate), (m_mode == M_ATK || m_mode == M_SUS) ? 1 : 0);
        check("voice_active", 32'(ne.voice_active), (m_mode != M_IDLE) ? 1 : 0);
        check("note_idx", 32'(ne.note_idx), m_note);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_phase"}, 32'(ne.phase_inc), 0);
        check({tag, "_amp"}, 32'(ne.amp), 0);
        check({tag, "_gate"}, 32'(ne.gate), 0);
        check({tag, "_active"}, 32'(ne.voice_active), 0);
        check({tag, "_note"}, 32'(ne.note_idx), 0);
    endtask

    task automatic step(input int key, input bit tick);
        ne.key_idx     = 4'(key);
        ne.sample_tick = tick;
`ifdef NOTE_OCTAVE_SHIFT_EN
        ne.octave      = 2'(cur_oct);
`endif
        @(posedge clk);
        model_clock(key, tick, cur_oct);
        #1;
        check_all();
    endtask

    task automatic ticks(input int key, input int n, input int period);
        repeat (n) begin
            repeat (period - 1) step(key, 1'b0);
            step(key, 1'b1);
        end
    endtask

    task automatic drain();
        int n;
        repeat (2) step(0, 1'b0);
        n = m_amp / 16 + 3;
        repeat (n) step(0, 1'b1);
        check("drain_idle", 32'(ne.voice_active), 0);
    endtask

    initial begin
        ne.key_idx     = 4'd0;
        ne.sample_tick = 1'b0;
`ifdef NOTE_OCTAVE_SHIFT_EN
        ne.octave      = 2'd0;
`endif
        model_reset();

        // Reset with ticks running, then release.
        repeat (4) begin
            @(posedge clk); #1;
            ne.sample_tick = ~ne.sample_tick;
            check_zero("reset");
        end
        ne.sample_tick = 1'b0;
        reset_n = 1'b1;
        repeat (4) step(0, 1'b1);
        check_zero("post_reset");

        // Press 10: gate two clocks later, attack to full scale, sustain.
        step(10, 1'b0);
        check("gate_early", 32'(ne.gate), 0);
        step(10, 1'b0);
        check("gate_rise", 32'(ne.gate), 1);
        check("inc_k10", 32'(ne.phase_inc), 153791);
        check("note_k10", 32'(ne.note_idx), 10);
        ticks(10, 1023, 4);
        check("amp_1023", 32'(ne.amp), 65472);
        ticks(10, 1, 4);
        check("amp_full", 32'(ne.amp), FULL);
        ticks(10, 5, 4);
        check("sustain_hold", 32'(ne.amp), FULL);

        // Release to silence.
        step(0, 1'b0);
        step(0, 1'b0);
        check("rel_gate", 32'(ne.gate), 0);
        check("rel_active", 32'(ne.voice_active), 1);
        ticks(0, 4095, 4);
        check("amp_4095", 32'(ne.amp), 15);
        ticks(0, 1, 4);
        check("idle_active", 32'(ne.voice_active), 0);
        check("idle_note", 32'(ne.note_idx), 0);
        check("idle_inc_hold", 32'(ne.phase_inc), 153791);

        // Legato change during attack, event beats coincident tick.
        step(1, 1'b0);
        step(1, 1'b0);
        check("inc_k1", 32'(ne.phase_inc), 91445);
        ticks(1, 10, 2);
        check("legato_amp", 32'(ne.amp), 640);
        step(10, 1'b0);
        step(10, 1'b1);
        check("legato_inc", 32'(ne.phase_inc), 153791);
        check("legato_hold", 32'(ne.amp), 640);
        step(10, 1'b1);
        check("legato_step", 32'(ne.amp), 704);
        drain();

        // Retrigger from release with a coincident tick.
        step(1, 1'b0);
        step(1, 1'b0);
        repeat (17) step(1, 1'b1);
        step(0, 1'b0);
        step(0, 1'b0);
        repeat (5) step(0, 1'b1);
        check("retrig_pre", 32'(ne.amp), 1008);
        step(3, 1'b0);
        step(3, 1'b1);
        check("retrig_gate", 32'(ne.gate), 1);
        check("retrig_hold", 32'(ne.amp), 1008);
        check("retrig_note", 32'(ne.note_idx), 3);
        check("retrig_inc", 32'(ne.phase_inc), 102643);
        step(3, 1'b1);
        check("retrig_step", 32'(ne.amp), 1072);
        drain();

`ifdef NOTE_OCTAVE_SHIFT_EN
        cur_oct = 2;
        step(10, 1'b0);
        step(10, 1'b0);
        check("oct_inc", 32'(ne.phase_inc), 615164);
        cur_oct = 0;
        repeat (3) step(10, 1'b1);
        check("oct_held", 32'(ne.phase_inc), 615164);
        drain();
`endif

        // Random key runs, including out-of-range indices, with sparse ticks.
        repeat (150) begin
            int key, len;
            key = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            len = $urandom_range(1, 30);
`ifdef NOTE_OCTAVE_SHIFT_EN
            cur_oct = $urandom_range(0, 3);
`endif
            repeat (len) step(key, $urandom_range(0, 2) == 0);
        end

        // Asynchronous reset in the middle of a note.
        step(5, 1'b0);
        step(5, 1'b0);
        ticks(5, 4, 2);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_zero("async_reset");
        repeat (3) begin
            @(posedge clk); #1;
            check_zero("reset_hold");
        end
        reset_n = 1'b1;
        step(0, 1'b1);
        step(7, 1'b0);
        step(7, 1'b0);
        check("after_reset_gate", 32'(ne.gate), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
